// File: rtl/single_port_ram_init_if.sv
// Access bus for single_port_ram_init: request/write side driven by the master,
// read data and status returned by the RAM.
interface single_port_ram_init_if #(
   parameter int DATA_WIDTH = 16,
   parameter int LANE_WIDTH = 8,
   parameter int ADDR_WIDTH = 6
);
   localparam int LANES = DATA_WIDTH / LANE_WIDTH;

   logic                  en;
   logic [LANES-1:0]      we;
   logic                  clr;
   logic [ADDR_WIDTH-1:0] address;
   logic [DATA_WIDTH-1:0] DI;
   logic [DATA_WIDTH-1:0] DO;
   logic                  rd_valid;
   logic                  busy;

   modport master (
      output en, we, clr, address, DI,
      input  DO, rd_valid, busy
   );

   modport slave (
      input  en, we, clr, address, DI,
      output DO, rd_valid, busy
   );
endinterface

// File: rtl/single_port_ram_init.sv
// Parametrised single-port RAM with per-lane write enables, async or registered
// read, and a clear engine that sweeps every word to INIT_VALUE.
module spram_lane_merge #(
   parameter int W = 8
) (
   input  logic         i_we,
   input  logic [W-1:0] i_new,
   input  logic [W-1:0] i_old,
   output logic [W-1:0] o_word
);
   assign o_word = i_we ? i_new : i_old;
endmodule

module single_port_ram_init #(
   parameter int                   DATA_WIDTH = 16,
   parameter int                   LANE_WIDTH = 8,
   parameter int                   ADDR_WIDTH = 6,
   parameter int                   READ_MODE  = 0,
   parameter int                   RDW_MODE   = 0,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
   input logic                    CLK,
   input logic                    RST,
   single_port_ram_init_if.slave  bus
);
   localparam int LANES = DATA_WIDTH / LANE_WIDTH;
   localparam int DEPTH = 2 ** ADDR_WIDTH;

   typedef enum logic {CLEAR, IDLE} state_t;

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_ptr;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   logic                  w_busy;
   logic                  w_accept;
   logic                  w_wr;
   logic                  w_rd;
   logic [DATA_WIDTH-1:0] w_old;
   logic [DATA_WIDTH-1:0] w_merged;

   assign w_busy   = (r_state == CLEAR);
   assign w_accept = ~w_busy & bus.en & ~bus.clr;
   assign w_wr     = w_accept & (|bus.we);
   assign w_rd     = ~(|bus.we);
   assign w_old    = r_mem[bus.address];
   assign bus.busy = w_busy;

   genvar g;
   generate
      for (g = 0; g < LANES; g++) begin : g_lane
         spram_lane_merge #(.W(LANE_WIDTH)) u_lane (
            .i_we   (bus.we[g]),
            .i_new  (bus.DI[g*LANE_WIDTH +: LANE_WIDTH]),
            .i_old  (w_old[g*LANE_WIDTH +: LANE_WIDTH]),
            .o_word (w_merged[g*LANE_WIDTH +: LANE_WIDTH])
         );
      end
   endgenerate

   // Sweep ends on the edge that writes the last word; ptr wraps back to 0.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= CLEAR;
         r_ptr   <= '0;
      end else begin
         case (r_state)
            CLEAR: begin
               r_ptr <= r_ptr + 1'b1;
               if (&r_ptr) r_state <= IDLE;
            end
            IDLE: begin
               if (bus.clr) begin
                  r_state <= CLEAR;
                  r_ptr   <= '0;
               end
            end
            default: r_state <= CLEAR;
         endcase
      end
   end

   // Storage kept free of reset so it can map onto RAM primitives.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         if (w_busy)    r_mem[r_ptr]       <= INIT_VALUE;
         else if (w_wr) r_mem[bus.address] <= w_merged;
      end
   end

   generate
      if (READ_MODE == 0) begin : g_async
         assign bus.DO       = w_old;
         assign bus.rd_valid = bus.en & ~w_busy & w_rd;
      end else begin : g_reg
         logic [DATA_WIDTH-1:0] r_do;
         logic                  r_rd_valid;

         always_ff @(posedge CLK) begin
            if (RST) begin
               r_do       <= '0;
               r_rd_valid <= 1'b0;
            end else begin
               r_rd_valid <= w_accept & w_rd;
               if (w_accept) r_do <= (RDW_MODE != 0) ? w_merged : w_old;
            end
         end

         assign bus.DO       = r_do;
         assign bus.rd_valid = r_rd_valid;
      end
   endgenerate
endmodule

// File: doc/single_port_ram_init.md
# single_port_ram_init

Parametrised single-port synchronous-write RAM; successor to the fixed 64×16 async-read RAM. Adds configurable width/depth, per-lane write enables, selectable asynchronous or registered read with defined read-during-write behaviour, and a hardware clear engine that sweeps every location to `INIT_VALUE` after reset or on request. Serves as the general on-chip storage primitive for datapath blocks; maps to distributed or block RAM depending on `READ_MODE`.

## Interface
- `DATA_WIDTH`, 16: word width in bits; must be a multiple of `LANE_WIDTH`.
- `LANE_WIDTH`, 8: bits per write-enable lane; `LANES = DATA_WIDTH/LANE_WIDTH`.
- `ADDR_WIDTH`, 6: address bits; `DEPTH = 2**ADDR_WIDTH`.
- `READ_MODE`, 0: 0 = asynchronous read, 1 = registered read.
- `RDW_MODE`, 0: registered mode only; 0 = read-first (old data), 1 = write-first (new merged data).
- `INIT_VALUE`, 0: `DATA_WIDTH`-bit word written to every location by the clear engine.

Ports:
- `CLK`  in  1  single clock; all state updates on rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `en`  in  1  access request; ignored while `busy`.
- `we`  in  `LANES`  per-lane write enable; all-zero with `en` = read.
- `clr`  in  1  request a full clear sweep.
- `address`  in  `ADDR_WIDTH`  word address.
- `DI`  in  `DATA_WIDTH`  write data.
- `DO`  out  `DATA_WIDTH`  read data.
- `rd_valid`  out  1  read data qualifier.
- `busy`  out  1  clear engine active; accesses dropped.

## Operation
- States: `CLEAR`, `IDLE`. Sweep pointer `ptr` is `ADDR_WIDTH` bits.
- `RST`=1 (any state): state ← `CLEAR`, `ptr` ← 0, registered `DO` ← 0, `rd_valid` ← 0; no memory write occurs while `RST`=1.
- `CLEAR`, `RST`=0: mem[`ptr`] ← `INIT_VALUE`, `ptr` ← `ptr`+1; when `ptr`=`DEPTH`-1 write and go to `IDLE` (ptr wraps to 0).
- `IDLE`, `clr`=1: state ← `CLEAR`, `ptr` ← 0; `clr` has priority, the same-cycle access is dropped.
- `IDLE`, `en`=1, `clr`=0: for each lane i with `we[i]`=1, mem[address] lane i ← `DI` lane i; other lanes unchanged.
- `busy` = 1 in `CLEAR` (including while `RST`=1), 0 in `IDLE`; combinational from state.
- `en`/`we`/`clr` during `CLEAR` ignored; `clr` during `CLEAR` does not restart the sweep.
- `READ_MODE`=0: `DO` = mem[`address`] combinationally at all times (also during `CLEAR`); `rd_valid` = `en` & ~`busy` & (`we`==0), combinational.
- `READ_MODE`=1: on accepted access (`IDLE`, `en`=1, `clr`=0), `DO` ← mem[address] (RDW 0) or merged post-write word (RDW 1); otherwise `DO` holds. `rd_valid` ← 1 the cycle after an accepted access with `we`==0, else 0. Partial-lane write with RDW 1: `DO` shows new lanes for enabled lanes, old contents for others.
- Address range is full power-of-two; no out-of-range case.

## Timing
- Reset: outputs after first edge with `RST`=1: `busy`=1, `rd_valid`=0, registered `DO`=0.
- Clear duration: `busy` stays high exactly `DEPTH` cycles after the first edge with `RST`=0 (or the edge sampling `clr`); first access accepted on the following edge.
- `RST` asserted mid-sweep: sweep restarts at `ptr`=0 after release; full `DEPTH` cycles again.
- Write latency: 1 edge; async read reflects write immediately after that edge.
- Registered read latency: 1 cycle; back-to-back accesses every cycle, no bubbles.

## Test plan
- Reset release, `ADDR_WIDTH`=6: `busy` high 64 cycles after `RST` drops; then reads of addresses 0, 31, 63 return `INIT_VALUE` (e.g. 16'hA5A5).
- Lane writes: mem[5]=16'h1234, then `we`=2'b10, `DI`=16'hABCD at 5 -> read returns 16'hAB34.
- Registered RDW: mem[9]=16'h0001, write 16'h00FF at 9 with read capture -> `DO`=16'h0001 (RDW 0) / 16'h00FF (RDW 1) next cycle; `rd_valid`=0 for that write, 1 after a following pure read.
- `clr` with same-cycle write of 16'hFFFF at 3 -> write dropped, `busy` 64 cycles, mem[3]=`INIT_VALUE` afterwards.
- `RST` pulse at sweep cycle 20 -> `busy` remains high 64 further cycles after release; all locations `INIT_VALUE`.
- Accesses during `busy` (`en`=1, `we`=all ones, `DI`=16'hDEAD at 7) -> no effect, `rd_valid`=0, mem[7]=`INIT_VALUE`.
